// File: rtl/bb8051_muldiv_ctrl.sv
// bb8051_muldiv_ctrl
// Multi-cycle sequencer for the 8051 MUL AB / DIV AB instructions.
// Latches A and B on an accepted start and runs an 8-step shift-add multiply
// or restoring divide. It then issues one coordinated write of A, B (byte
// write) and PSW.OV/CY.
// Optional build macro: BB8051_MULDIV_FAST_MUL_EN. When it is defined, MUL
// is computed in a single cycle and skips the iterative CALC phase. DIV
// timing is the same in both builds.
// All outputs come straight from flops. Data outputs read zero whenever
// their strobe is low.

module bb8051_muldiv_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] acc_in,
    input  logic [7:0] b_in,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       acc_we,
    output logic [7:0] acc_wr_data,
    output logic       b_we,
    output logic [7:0] b_wr_data,
    output logic       psw_we,
    output logic       psw_ov,
    output logic       psw_cy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        op_q, op_d;

    // multiply datapath: multiplicand plus a combined product/multiplier register
    logic [7:0]  mcand_q, mcand_d;
    logic [15:0] prod_q, prod_d;

    // divide datapath: divisor, shifting dividend, partial remainder, quotient
    logic [7:0]  divisor_q, divisor_d;
    logic [7:0]  dvd_q, dvd_d;
    logic [7:0]  rem_q, rem_d;
    logic [7:0]  quot_q, quot_d;

    // next values for the registered outputs
    logic        busy_d;
    logic        done_d;
    logic        acc_we_d;
    logic        b_we_d;
    logic        psw_we_d;
    logic        psw_ov_d;
    logic [7:0]  acc_wr_data_d;
    logic [7:0]  b_wr_data_d;

    // one iteration of each algorithm, computed from the current registers
    logic [8:0]  mul_sum;
    logic [15:0] mul_step;
    logic [8:0]  div_trial;
    logic        div_ge;
    logic [7:0]  div_rem_step;
    logic [7:0]  div_quot_step;
    logic [7:0]  div_dvd_step;

`ifdef BB8051_MULDIV_FAST_MUL_EN
    logic [15:0] fast_prod;

    // single-cycle product used when the fast multiplier is built in
    always_comb begin
        fast_prod = {8'h00, acc_in} * {8'h00, b_in};
    end
`endif

    // CY is defined to be cleared by both instructions
    assign psw_cy = 1'b0;

    // one shift-add and one restoring-subtract step
    always_comb begin
        // add the multiplicand into the upper half when the multiplier LSB
        // is set; the ninth sum bit becomes the new product MSB on the shift
        mul_sum  = {1'b0, prod_q[15:8]} + (prod_q[0] ? {1'b0, mcand_q} : 9'd0);
        mul_step = {mul_sum, prod_q[7:1]};

        // bring the next dividend bit into the remainder; the 9-bit compare
        // covers a remainder that has grown past 8 bits before subtracting
        div_trial     = {rem_q, dvd_q[7]};
        div_ge        = (div_trial >= {1'b0, divisor_q});
        div_rem_step  = div_ge ? (div_trial[7:0] - divisor_q) : div_trial[7:0];
        div_quot_step = {quot_q[6:0], div_ge};
        div_dvd_step  = {dvd_q[6:0], 1'b0};
    end

    // sequencer: next state, datapath loads and next output values
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        mcand_d       = mcand_q;
        prod_d        = prod_q;
        divisor_d     = divisor_q;
        dvd_d         = dvd_q;
        rem_d         = rem_q;
        quot_d        = quot_q;
        done_d        = 1'b0;
        acc_we_d      = 1'b0;
        b_we_d        = 1'b0;
        psw_we_d      = 1'b0;
        psw_ov_d      = 1'b0;
        acc_wr_data_d = 8'h00;
        b_wr_data_d   = 8'h00;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    op_d      = op;
                    mcand_d   = acc_in;
                    prod_d    = {8'h00, b_in};
                    divisor_d = b_in;
                    dvd_d     = acc_in;
                    rem_d     = 8'h00;
                    quot_d    = 8'h00;
                    cnt_d     = 3'd0;
                    if (op && (b_in == 8'h00)) begin
                        // divide by zero: flag OV only, A and B untouched
                        state_d  = WRITE;
                        done_d   = 1'b1;
                        psw_we_d = 1'b1;
                        psw_ov_d = 1'b1;
                    end
`ifdef BB8051_MULDIV_FAST_MUL_EN
                    else if (!op) begin
                        state_d       = WRITE;
                        done_d        = 1'b1;
                        acc_we_d      = 1'b1;
                        b_we_d        = 1'b1;
                        psw_we_d      = 1'b1;
                        acc_wr_data_d = fast_prod[7:0];
                        b_wr_data_d   = fast_prod[15:8];
                        psw_ov_d      = (fast_prod[15:8] != 8'h00);
                    end
`endif
                    else begin
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (op_q) begin
                        rem_d  = div_rem_step;
                        quot_d = div_quot_step;
                        dvd_d  = div_dvd_step;
                    end else begin
                        prod_d = mul_step;
                    end
                    if (cnt_q == 3'd7) begin
                        // last iteration: load the write cycle from this step's result
                        state_d  = WRITE;
                        done_d   = 1'b1;
                        acc_we_d = 1'b1;
                        b_we_d   = 1'b1;
                        psw_we_d = 1'b1;
                        if (op_q) begin
                            acc_wr_data_d = div_quot_step;
                            b_wr_data_d   = div_rem_step;
                            psw_ov_d      = 1'b0;
                        end else begin
                            acc_wr_data_d = mul_step[7:0];
                            b_wr_data_d   = mul_step[15:8];
                            psw_ov_d      = (mul_step[15:8] != 8'h00);
                        end
                    end
                end
            end

            WRITE: begin
                // the write always completes; abort cannot reach here
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            op_q      <= 1'b0;
            mcand_q   <= 8'h00;
            prod_q    <= 16'h0000;
            divisor_q <= 8'h00;
            dvd_q     <= 8'h00;
            rem_q     <= 8'h00;
            quot_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            divisor_q <= divisor_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
        end
    end

    // registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            acc_we      <= 1'b0;
            b_we        <= 1'b0;
            psw_we      <= 1'b0;
            psw_ov      <= 1'b0;
            acc_wr_data <= 8'h00;
            b_wr_data   <= 8'h00;
        end else begin
            busy        <= busy_d;
            done        <= done_d;
            acc_we      <= acc_we_d;
            b_we        <= b_we_d;
            psw_we      <= psw_we_d;
            psw_ov      <= psw_ov_d;
            acc_wr_data <= acc_wr_data_d;
            b_wr_data   <= b_wr_data_d;
        end
    end

endmodule

// File: tb/tb_bb8051_muldiv_ctrl.sv
// Self-checking bench for bb8051_muldiv_ctrl.
// Expected results come from a behavioural model and are queued on start.
// They are popped and compared when done is seen.
// Build with BB8051_MULDIV_FAST_MUL_EN to exercise the single-cycle multiply build.

module tb_bb8051_muldiv_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       op;
    logic [7:0] acc_in;
    logic [7:0] b_in;
    logic       abort;
    logic       busy;
    logic       done;
    logic       acc_we;
    logic [7:0] acc_wr_data;
    logic       b_we;
    logic [7:0] b_wr_data;
    logic       psw_we;
    logic       psw_ov;
    logic       psw_cy;

    logic [22:0] all_out;
    assign all_out = {busy, done, acc_we, b_we, psw_we, psw_ov, psw_cy, acc_wr_data, b_wr_data};

`ifdef BB8051_MULDIV_FAST_MUL_EN
    localparam int  MUL_LAT = 1;
    localparam logic SEQ_OP = 1'b1;
`else
    localparam int  MUL_LAT = 9;
    localparam logic SEQ_OP = 1'b0;
`endif

    typedef struct {
        logic       acc_we;
        logic       b_we;
        logic       ov;
        logic [7:0] acc_d;
        logic [7:0] b_d;
        int         latency;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    bb8051_muldiv_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .acc_in      (acc_in),
        .b_in        (b_in),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .acc_we      (acc_we),
        .acc_wr_data (acc_wr_data),
        .b_we        (b_we),
        .b_wr_data   (b_wr_data),
        .psw_we      (psw_we),
        .psw_ov      (psw_ov),
        .psw_cy      (psw_cy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // hard stop in case the sequence itself stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t model(input logic o, input logic [7:0] a, input logic [7:0] b);
        exp_t        e;
        logic [15:0] p;
        if (!o) begin
            p         = {8'h00, a} * {8'h00, b};
            e.acc_we  = 1'b1;
            e.b_we    = 1'b1;
            e.acc_d   = p[7:0];
            e.b_d     = p[15:8];
            e.ov      = (p[15:8] != 8'h00);
            e.latency = MUL_LAT;
        end else if (b == 8'h00) begin
            e.acc_we  = 1'b0;
            e.b_we    = 1'b0;
            e.acc_d   = 8'h00;
            e.b_d     = 8'h00;
            e.ov      = 1'b1;
            e.latency = 1;
        end else begin
            e.acc_we  = 1'b1;
            e.b_we    = 1'b1;
            e.acc_d   = a / b;
            e.b_d     = a % b;
            e.ov      = 1'b0;
            e.latency = 9;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // drive one start for one cycle; queue its expected result if it should be accepted
    task automatic applyStimulus(input logic o, input logic [7:0] a, input logic [7:0] b,
                                 input bit accept);
        op     = o;
        acc_in = a;
        b_in   = b;
        start  = 1'b1;
        if (accept) sb.push_back(model(o, a, b));
        tick();
        start  = 1'b0;
    endtask

    // wait for done, then compare the write cycle and the cycle after it
    task automatic waitAndCheck(input string tag, input int first_cycle);
        int   cyc;
        exp_t e;
        cyc = first_cycle;
        while (done !== 1'b1 && cyc < first_cycle + 20) begin
            tick();
            cyc++;
        end
        if (done !== 1'b1) begin
            checkOutput({tag, ".timeout"}, {31'd0, done}, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        checkOutput({tag, ".sb_entry"}, (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        checkOutput({tag, ".cycle"}, cyc, e.latency);
        checkOutput({tag, ".busy"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, ".strobes"}, {29'd0, acc_we, b_we, psw_we}, {29'd0, e.acc_we, e.b_we, 1'b1});
        checkOutput({tag, ".acc"}, {24'd0, acc_wr_data}, {24'd0, e.acc_d});
        checkOutput({tag, ".b"}, {24'd0, b_wr_data}, {24'd0, e.b_d});
        checkOutput({tag, ".psw"}, {30'd0, psw_ov, psw_cy}, {30'd0, e.ov, 1'b0});
        tick();
        checkOutput({tag, ".after"}, {9'd0, all_out}, 32'd0);
    endtask

    initial begin
        logic       ro;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       seen;

        rst    = 1'b1;
        start  = 1'b0;
        op     = 1'b0;
        abort  = 1'b0;
        acc_in = 8'h00;
        b_in   = 8'h00;

        // reset state held and after release
        tick();
        checkOutput("reset.hold", {9'd0, all_out}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("reset.release", {9'd0, all_out}, 32'd0);

        // directed multiplies and divides
        applyStimulus(1'b0, 8'h50, 8'hA0, 1'b1);
        waitAndCheck("mul_50xA0", 1);
        applyStimulus(1'b0, 8'h0F, 8'h0F, 1'b1);
        waitAndCheck("mul_0Fx0F", 1);
        applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b1);
        waitAndCheck("mul_FFxFF", 1);
        applyStimulus(1'b1, 8'hFB, 8'h12, 1'b1);
        waitAndCheck("div_FB_12", 1);
        applyStimulus(1'b1, 8'h07, 8'h09, 1'b1);
        waitAndCheck("div_07_09", 1);
        applyStimulus(1'b1, 8'h12, 8'h00, 1'b1);
        waitAndCheck("div_by_zero", 1);

        // operand changes and a second start while busy are ignored
        applyStimulus(SEQ_OP, 8'h03, 8'h05, 1'b1);
        tick();
        acc_in = 8'hAA;
        b_in   = 8'h55;
        tick();
        start  = 1'b1;
        op     = ~SEQ_OP;
        acc_in = 8'h99;
        b_in   = 8'h07;
        tick();
        start  = 1'b0;
        waitAndCheck("ignore", 4);
        tick();
        checkOutput("ignore.no_queue", {30'd0, busy, done}, 32'd0);

        // abort in CALC, then a fresh start right after
        applyStimulus(SEQ_OP, 8'h21, 8'h04, 1'b0);
        tick();
        tick();
        checkOutput("abort.c3", {30'd0, busy, done}, 32'd2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort.c5", {27'd0, busy, done, acc_we, b_we, psw_we}, 32'd0);
        applyStimulus(1'b1, 8'h64, 8'h0A, 1'b1);
        waitAndCheck("abort.restart", 1);

        // abort in the same cycle as start drops the start
        abort = 1'b1;
        applyStimulus(1'b0, 8'h05, 8'h05, 1'b0);
        abort = 1'b0;
        checkOutput("abort_start.busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | busy | done | acc_we | b_we | psw_we;
        end
        checkOutput("abort_start.quiet", {31'd0, seen}, 32'd0);

        // asynchronous reset in the middle of a divide
        applyStimulus(1'b1, 8'hFB, 8'h12, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1;
        checkOutput("rst_mid.outputs", {9'd0, all_out}, 32'd0);
        sb.delete();
        tick();
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | busy | done | acc_we | b_we | psw_we;
        end
        checkOutput("rst_mid.no_write", {31'd0, seen}, 32'd0);
        applyStimulus(1'b0, 8'h02, 8'h03, 1'b1);
        waitAndCheck("rst_mid.mul_2x3", 1);

        // a handful of random operations against the model
        for (int i = 0; i < 8; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            applyStimulus(ro, ra, rb, 1'b1);
            waitAndCheck("random", 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bb8051_muldiv_ctrl.md
# bb8051_muldiv_ctrl

Multi-cycle sequencer for the 8051 MUL AB / DIV AB instructions. It latches the A and B operands on a start request, runs an 8-iteration shift-add (MUL) or restoring-subtract (DIV) loop, then issues one coordinated write cycle to the accumulator, the B register (byte write) and PSW.OV/CY. It sits between the instruction decoder and the A/B/PSW SFR blocks and owns the B register's write port while busy.

## Interface
- No parameters.
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = MUL AB, 1 = DIV AB; sampled with start
- acc_in  in  8  current A value; sampled with start
- b_in  in  8  current B value; sampled with start
- abort  in  1  synchronous cancel; highest priority after rst
- busy  out  1  high from the cycle after accepted start until the cycle after WRITE
- done  out  1  one-cycle pulse in the WRITE cycle
- acc_we  out  1  accumulator write strobe
- acc_wr_data  out  8  new A value
- b_we  out  1  B register byte-write strobe; the B wrapper maps it to `BB8051_SFR_ACT_WR_BYTE`
- b_wr_data  out  8  new B value
- psw_we  out  1  strobe for OV and CY
- psw_ov  out  1  OV value
- psw_cy  out  1  CY value; always 0

## Operation
- States: IDLE, CALC, WRITE.
- IDLE:
  - start=1 latches op, acc_in and b_in into internal operand registers.
  - Later changes on acc_in/b_in are ignored.
- DIV with b_in=0:
  - Transition IDLE→WRITE.
  - In WRITE: acc_we=b_we=0, psw_we=1, psw_ov=1, psw_cy=0. A and B are left unchanged.
- All other starts: IDLE→CALC with the 3-bit iteration counter cleared.
- CALC, MUL:
  - 16-bit product register.
  - Each cycle, test the LSB of the multiplier, conditionally add the multiplicand into the upper half, then shift right 1.
- CALC, DIV:
  - 8-bit remainder register and 8-bit quotient register.
  - Each cycle, shift the dividend MSB into the remainder.
  - If remainder ≥ divisor, subtract it and shift 1 into the quotient; else shift 0.
  - The compare uses a 9-bit width so no overflow occurs.
- CALC exit: counter 7→0 wraps; the cycle after counter==7, go to WRITE.
- WRITE, MUL:
  - acc_wr_data = product[7:0], b_wr_data = product[15:8].
  - psw_ov = (product[15:8] != 0), psw_cy = 0.
  - All strobes high.
- WRITE, DIV:
  - acc_wr_data = quotient, b_wr_data = remainder.
  - psw_ov = 0, psw_cy = 0.
  - All strobes high.
- After WRITE: always go to IDLE.
- start while busy: ignored; no queueing.
- abort:
  - In CALC, abort=1 returns to IDLE next cycle with no write strobes and no done.
  - abort in the same cycle as an IDLE start: the start is dropped.
  - abort in WRITE: no effect; the write completes.
- Reset:
  - rst mid-operation forces IDLE immediately.
  - Internal registers clear; no write occurs.

## Timing
- All outputs are registered.
- Reset value: every output 0; state IDLE.
- Start accepted at edge 0.
- Normal op:
  - busy=1 cycles 1–9.
  - CALC occupies cycles 1–8.
  - WRITE, done and strobes occur in cycle 9.
  - busy=0 from cycle 10.
  - Next start can be accepted at edge 10 (the edge where busy is seen low).
- DIV by zero: WRITE/done in cycle 1, busy=0 from cycle 2.
- Strobes and done are high for exactly one cycle. Data outputs hold their value only while the strobe is high; they are 0 otherwise.

## Configuration
- `BB8051_MULDIV_FAST_MUL_EN`:
  - Defined: MUL computes the 8×8 product combinationally at start and goes IDLE→WRITE. done and strobes occur in cycle 1, busy=0 from cycle 2.
  - Defined: DIV timing is unchanged.
  - Undefined: MUL uses the iterative 8-cycle CALC path described above.

## Test plan
- MUL, acc_in=0x50, b_in=0xA0 → cycle 9: acc_wr_data=0x00, b_wr_data=0x32, psw_ov=1, psw_cy=0, done=1. With FAST_MUL_EN, the same values appear in cycle 1.
- MUL, 0x0F×0x0F → acc_wr_data=0xE1, b_wr_data=0x00, psw_ov=0. Also 0xFF×0xFF → 0x01 / 0xFE, psw_ov=1.
- DIV, acc_in=0xFB (251), b_in=0x12 (18) → cycle 9: acc_wr_data=0x0D, b_wr_data=0x11, psw_ov=0. Also 0x07/0x09 → 0x00 / 0x07.
- DIV, acc_in=0x12, b_in=0x00 → cycle 1: done=1, psw_we=1, psw_ov=1, acc_we=b_we=0. busy=0 at cycle 2.
- Start MUL, then pulse start again (with new operands) at cycle 3, and change acc_in at cycle 2 → both ignored; results match the original operands. In a second run, abort at cycle 4 → no strobes, no done, busy=0 at cycle 5, and a new start is accepted at cycle 5.
- Assert rst at cycle 5 of a DIV → all outputs 0 immediately, no WRITE afterwards. After release, a MUL 0x02×0x03 gives acc_wr_data=0x06.
